// File: rtl/mdu_sched.sv
// Multiply/divide unit scheduler: models the fixed-latency HI/LO unit, holding a
// computed result in pending registers until the busy window expires.
module mdu_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  input  logic        d_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state
);

  // Handshake: start is a single-cycle strobe taken only in IDLE (kill drops it);
  // busy rises the cycle after acceptance and new hi/lo are visible when it falls.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;
  logic        commit;

  logic        valid_op, long_op, is_div, acc;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_nz, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign valid_op = (op != 3'd0) && (op != 3'd7);
  assign long_op  = (op >= 3'd1) && (op <= 3'd4);
  assign is_div   = (op == 3'd3) || (op == 3'd4);
  assign acc      = start && !kill && valid_op && (state == IDLE);

  // Divisor is forced nonzero so the datapath stays defined; the b==0 result
  // is discarded at commit anyway.
  assign b_nz   = (b == 32'd0) ? 32'd1 : b;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_s    = $signed(a) / $signed(b_nz);
  assign r_s    = $signed(a) % $signed(b_nz);
  assign q_u    = a / b_nz;
  assign r_u    = a % b_nz;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      3'd1:    {res_hi, res_lo} = prod_s;
      3'd2:    {res_hi, res_lo} = prod_u;
      3'd3:    begin res_hi = r_s; res_lo = q_s; end
      3'd4:    begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (acc && long_op) begin
          state_nx = RUN;
          cnt_nx   = is_div ? DIV_LD : MULT_LD;
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (acc && long_op) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= !(is_div && (b == 32'd0));
      end
      if (commit && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (acc && op == 3'd5) hi <= a;
      if (acc && op == 3'd6) lo <= a;
    end
  end

  assign busy      = (state == RUN);
  assign dbg_state = (state == RUN);
  assign stall_md  = d_md && (busy || (start && !kill && long_op));

endmodule
